// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS run monitor: FSM states,
// stop-cause codes and a constant ceil(log2) helper.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_EXT    = 2'd1;
    localparam logic [1:0] CAUSE_STABLE = 2'd2;
    localparam logic [1:0] CAUSE_TMO    = 2'd3;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Dump record channel: valid/ready with index, data, last.
// master = monitor (producer), slave = consumer.
interface mips_run_monitor_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) ();
    import mips_dbg_pkg::*;

    localparam int IDX_W = clog2(NUM_REGS + 1);

    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_index,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_index,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/dump_skid_reg.sv
// Single-entry output register for the dump channel.
// Ports: clk, reset, flush, load + record in, dump (master).
module dump_skid_reg #(
    parameter int IDX_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    mips_run_monitor_if.master dump
);

    // load is only raised by the owner when the slot is empty
    // or being drained this cycle, so nothing is overwritten.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            dump.dump_valid <= 1'b0;
            dump.dump_index <= '0;
            dump.dump_data  <= '0;
            dump.dump_last  <= 1'b0;
        end else if (load) begin
            dump.dump_valid <= 1'b1;
            dump.dump_index <= in_index;
            dump.dump_data  <= in_data;
            dump.dump_last  <= in_last;
        end else if (dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Run control + state dump: runs the CPU until halt/self-loop/
// timeout, stalls it, then streams PC and all registers out.
// Ports: clk, reset, start, halt_req, pc_in, rf_raddr/rf_rdata,
// cpu_stall, done, cause, cycle_count, dump (record channel).
module mips_run_monitor
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int PC_W           = 32,
    parameter int NUM_REGS       = 32,
    parameter int REG_AW         = 5,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 halt_req,
    input  logic [PC_W-1:0]                      pc_in,
    output logic [REG_AW-1:0]                    rf_raddr,
    input  logic [DATA_W-1:0]                    rf_rdata,
    output logic                                 cpu_stall,
    output logic                                 done,
    output logic [1:0]                           cause,
    output logic [clog2(TIMEOUT_CYCLES+1)-1:0]   cycle_count,
    mips_run_monitor_if.master                   dump
);

    localparam int IDX_W = clog2(NUM_REGS + 1);
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
    localparam int STB_W = clog2(STABLE_CYCLES + 1);

    state_t            state;
    logic [PC_W-1:0]   prev_pc;
    logic [PC_W-1:0]   halt_pc;
    logic [STB_W-1:0]  stable_cnt;
    logic [IDX_W-1:0]  idx;
    logic              all_loaded;

    logic              same;
    logic              hit_ext;
    logic              hit_stb;
    logic              hit_tmo;
    logic              stop;
    logic              load;
    logic              flush;
    logic              last_hs;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    assign same    = (pc_in == prev_pc);
    assign hit_ext = halt_req;
    // stable_cnt counts repeats seen so far; this cycle's repeat
    // completes the run of STABLE_CYCLES identical PCs.
    assign hit_stb = same &&
                     (stable_cnt == STB_W'(STABLE_CYCLES - 2));
    assign hit_tmo = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stop    = hit_ext || hit_stb || hit_tmo;

    assign load  = (state == DUMP) && !all_loaded &&
                   (!dump.dump_valid || dump.dump_ready);
    assign flush = start && ((state == IDLE) || (state == DONE));

    assign last_hs = dump.dump_valid && dump.dump_ready &&
                     dump.dump_last;

    generate
        if (PC_W >= DATA_W) begin : g_pc_trunc
            assign pc_ext = halt_pc[DATA_W-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DATA_W - PC_W){1'b0}}, halt_pc};
        end
    endgenerate

    // Record 0 is the PC; record k is register k-1, whose address
    // was put on rf_raddr when record k-1 was loaded.
    assign ld_data = (idx == '0) ? pc_ext : rf_rdata;
    assign ld_last = (idx == IDX_W'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prev_pc     <= '0;
            halt_pc     <= '0;
            stable_cnt  <= '0;
            idx         <= '0;
            all_loaded  <= 1'b0;
            rf_raddr    <= '0;
            cpu_stall   <= 1'b0;
            done        <= 1'b0;
            cause       <= CAUSE_NONE;
            cycle_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cycle_count <= '0;
                    stable_cnt  <= '0;
                    cause       <= CAUSE_NONE;
                    prev_pc     <= pc_in;
                    if (start) state <= RUN;
                end
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    prev_pc     <= pc_in;
                    stable_cnt  <= same ? stable_cnt + STB_W'(1)
                                        : '0;
                    if (stop) begin
                        state      <= DUMP;
                        halt_pc    <= pc_in;
                        cpu_stall  <= 1'b1;
                        idx        <= '0;
                        all_loaded <= 1'b0;
                        rf_raddr   <= '0;
                        if (hit_ext)
                            cause <= CAUSE_EXT;
                        else if (hit_stb)
                            cause <= CAUSE_STABLE;
                        else
                            cause <= CAUSE_TMO;
                    end
                end
                DUMP: begin
                    if (load) begin
                        rf_raddr <= REG_AW'(idx);
                        if (ld_last)
                            all_loaded <= 1'b1;
                        else
                            idx <= idx + IDX_W'(1);
                    end
                    if (last_hs) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state       <= RUN;
                        cpu_stall   <= 1'b0;
                        done        <= 1'b0;
                        cycle_count <= '0;
                        stable_cnt  <= '0;
                        cause       <= CAUSE_NONE;
                        prev_pc     <= pc_in;
                    end
                end
            endcase
        end
    end

    dump_skid_reg #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .load     (load),
        .in_index (idx),
        .in_data  (ld_data),
        .in_last  (ld_last),
        .dump     (dump)
    );

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: self-loop, timeout,
// priority, stalled consumer, mid-dump reset, restart from DONE.
module tb_mips_run_monitor;

    localparam int NREG = 32;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic [31:0] pc_in;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        cpu_stall;
    logic        done;
    logic [1:0]  cause;
    logic [6:0]  cycle_count;
    logic [31:0] rf [NREG];

    int vec;
    int errs;

    mips_run_monitor_if #(.NUM_REGS(NREG), .DATA_W(32)) dif ();

    mips_run_monitor #(
        .DATA_W         (32),
        .PC_W           (32),
        .NUM_REGS       (NREG),
        .REG_AW         (5),
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .pc_in       (pc_in),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .cpu_stall   (cpu_stall),
        .done        (done),
        .cause       (cause),
        .cycle_count (cycle_count),
        .dump        (dif)
    );

    assign rf_rdata = rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic load_rf(input logic [31:0] base);
        for (int k = 0; k < NREG; k++) rf[k] = base + 32'(k);
    endtask

    // Drain records, checking order and payload; tog selects the
    // 1,0,0,1 ready pattern. stop_at >= 0 returns with that
    // record pending and ready low.
    task automatic drain(input logic [31:0] epc,
                         input logic [31:0] base,
                         input bit tog,
                         input int stop_at);
        int nxt;
        int n;
        bit rdy;
        logic [31:0] ed;
        nxt = 0;
        n = 0;
        while (nxt <= NREG && n < 400) begin
            if (stop_at >= 0 && nxt == stop_at && dif.dump_valid) begin
                dif.dump_ready = 1'b0;
                chk("pend_idx", 64'(dif.dump_index), 64'(stop_at));
                return;
            end
            rdy = tog ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
            dif.dump_ready = rdy;
            if (n == 1) chk("first_valid", 64'(dif.dump_valid), 64'(1));
            if (dif.dump_valid) begin
                ed = (nxt == 0) ? epc : base + 32'(nxt - 1);
                chk("rec_idx", 64'(dif.dump_index), 64'(nxt));
                chk("rec_data", 64'(dif.dump_data), 64'(ed));
                chk("rec_last", 64'(dif.dump_last), 64'(nxt == NREG));
                if (rdy) nxt++;
            end
            tick;
            n++;
        end
        dif.dump_ready = 1'b0;
        if (stop_at >= 0) begin
            chk("pend_reached", 64'(nxt), 64'(stop_at));
        end else begin
            chk("drain_cnt", 64'(nxt), 64'(NREG + 1));
            chk("end_done", 64'(done), 64'(1));
            chk("end_valid", 64'(dif.dump_valid), 64'(0));
            chk("end_stall", 64'(cpu_stall), 64'(1));
        end
    endtask

    initial begin
        vec = 0;
        errs = 0;
        reset = 1'b1;
        start = 1'b0;
        halt_req = 1'b0;
        pc_in = '0;
        dif.dump_ready = 1'b0;
        load_rf(32'h1000);
        tick;
        tick;
        reset = 1'b0;

        chk("rst_valid", 64'(dif.dump_valid), 64'(0));
        chk("rst_stall", 64'(cpu_stall), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cause", 64'(cause), 64'(0));
        chk("rst_cc", 64'(cycle_count), 64'(0));
        chk("rst_raddr", 64'(rf_raddr), 64'(0));
        chk("rst_index", 64'(dif.dump_index), 64'(0));
        chk("rst_data", 64'(dif.dump_data), 64'(0));
        chk("rst_last", 64'(dif.dump_last), 64'(0));
        tick;

        // Run 1: PC climbs to 0x40 and sits there.
        pc_in = 32'h0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 19; c++) begin
            pc_in = (c < 15) ? 32'(4 * (c + 1)) : 32'h40;
            if (c == 18) chk("r1_pre_stall", 64'(cpu_stall), 64'(0));
            tick;
        end
        chk("r1_cause", 64'(cause), 64'(2));
        chk("r1_cc", 64'(cycle_count), 64'(19));
        chk("r1_stall", 64'(cpu_stall), 64'(1));
        chk("r1_valid0", 64'(dif.dump_valid), 64'(0));
        drain(32'h40, 32'h1000, 1'b1, -1);
        tick;
        tick;
        chk("r1_hold_done", 64'(done), 64'(1));
        chk("r1_hold_stall", 64'(cpu_stall), 64'(1));
        chk("r1_hold_cause", 64'(cause), 64'(2));
        chk("r1_hold_cc", 64'(cycle_count), 64'(19));

        // Run 2: restart from DONE, PC always moving -> timeout.
        load_rf(32'h2000);
        pc_in = 32'h1FC;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("r2_stall", 64'(cpu_stall), 64'(0));
        chk("r2_done", 64'(done), 64'(0));
        chk("r2_cc0", 64'(cycle_count), 64'(0));
        for (int c = 0; c < 100; c++) begin
            pc_in = 32'h200 + 32'(4 * c);
            start = (c == 50);
            if (c == 50) begin
                chk("r2_cc50", 64'(cycle_count), 64'(50));
                chk("r2_run_valid", 64'(dif.dump_valid), 64'(0));
            end
            tick;
        end
        start = 1'b0;
        chk("r2_cause", 64'(cause), 64'(3));
        chk("r2_cc", 64'(cycle_count), 64'(100));
        chk("r2_stall1", 64'(cpu_stall), 64'(1));
        drain(32'h38C, 32'h2000, 1'b0, -1);

        // Run 3: ext, stable and timeout coincide; reset mid-dump.
        load_rf(32'h3000);
        pc_in = 32'h3FC;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            pc_in = 32'h400 + 32'(4 * ((c < 96) ? c : 96));
            halt_req = (c == 99);
            tick;
        end
        halt_req = 1'b0;
        chk("r3_cause", 64'(cause), 64'(1));
        chk("r3_cc", 64'(cycle_count), 64'(100));
        drain(32'h580, 32'h3000, 1'b1, 10);
        reset = 1'b1;
        tick;
        chk("rr_valid", 64'(dif.dump_valid), 64'(0));
        chk("rr_stall", 64'(cpu_stall), 64'(0));
        chk("rr_done", 64'(done), 64'(0));
        chk("rr_cause", 64'(cause), 64'(0));
        chk("rr_cc", 64'(cycle_count), 64'(0));
        reset = 1'b0;
        dif.dump_ready = 1'b1;
        tick;
        chk("rr_no_more", 64'(dif.dump_valid), 64'(0));
        dif.dump_ready = 1'b0;

        // Run 4: fresh start from IDLE, external halt at cycle 3.
        load_rf(32'h4000);
        pc_in = 32'h7FC;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pc_in = 32'h800 + 32'(4 * c);
            halt_req = (c == 3);
            tick;
        end
        halt_req = 1'b0;
        chk("r4_cause", 64'(cause), 64'(1));
        chk("r4_cc", 64'(cycle_count), 64'(4));
        drain(32'h80C, 32'h4000, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, errs);
        $finish;
    end

endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Synthesizable run-control and state-dump unit for the MIPS core. It replaces the fixed-delay "run, then print registers" approach with hardware-detected completion.
- Starts a run, then detects program end by one of three events: the PC sits stable (a self-loop), an external halt request, or a cycle timeout.
- At end of run it freezes the CPU, then streams the final PC and every register-file entry out over a valid/ready channel.
- Sits beside the CPU. Taps the PC output and one register-file read port. Drives the CPU stall input.

Parameters:
- DATA_W, 32, register/record data width
- PC_W, 32, program counter width
- NUM_REGS, 32, register-file entries dumped
- REG_AW, 5, register read address width (2**REG_AW >= NUM_REGS)
- STABLE_CYCLES, 4, consecutive cycles of unchanged PC that count as a halt (>= 2)
- TIMEOUT_CYCLES, 4096, RUN cycles before forced stop (>= 1)

Ports:
- clk, in, 1, system clock, rising edge
- reset, in, 1, synchronous, active-high
- start, in, 1, single-cycle pulse; begins a run (honoured in IDLE and DONE only)
- halt_req, in, 1, external halt request (sampled in RUN only)
- pc_in, in, PC_W, current CPU PC
- rf_raddr, out, REG_AW, register-file read address
- rf_rdata, in, DATA_W, register-file read data (combinational, same cycle)
- cpu_stall, out, 1, freezes the CPU
- dump_valid, out, 1, record available
- dump_ready, in, 1, consumer accepts
- dump_index, out, clog2(NUM_REGS+1), 0 = PC, k = register k-1
- dump_data, out, DATA_W, record payload (PC zero-extended or truncated to DATA_W)
- dump_last, out, 1, marks the final record
- done, out, 1, dump complete
- cause, out, 2, 0 none, 1 external, 2 PC stable, 3 timeout
- cycle_count, out, clog2(TIMEOUT_CYCLES+1), RUN cycles elapsed

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - state = IDLE
  - all outputs 0; rf_raddr = 0
  - internal prev_pc and stable_cnt = 0
- States: IDLE, RUN, DUMP, DONE.
- IDLE:
  - start -> RUN
  - clear cycle_count, stable_cnt and cause; load prev_pc <= pc_in
- RUN (cycle_count += 1 each cycle):
  - stable_cnt: if pc_in == prev_pc then stable_cnt += 1, else stable_cnt = 0; prev_pc <= pc_in every cycle.
  - Stop conditions, evaluated on the current cycle's values:
    - ext: halt_req = 1
    - stable: stable_cnt == STABLE_CYCLES-2 and pc_in == prev_pc
    - tmo: cycle_count == TIMEOUT_CYCLES-1
  - Priority when several hold in the same cycle: ext > stable > tmo. cause is set to the winner.
  - On a stop: go to DUMP, latch halt_pc <= pc_in, and cycle_count takes its incremented value. After a timeout, cycle_count reads TIMEOUT_CYCLES.
  - start is ignored in RUN.
- DUMP:
  - cpu_stall = 1 from the first DUMP cycle onward (registered).
  - Record counter idx runs 0..NUM_REGS.
  - Output register loads when !dump_valid or (dump_valid && dump_ready):
    - idx = 0: dump_data = halt_pc
    - idx = k: rf_raddr = k-1, dump_data = rf_rdata
  - First dump_valid is asserted the cycle after entering DUMP.
  - While dump_valid = 1 and dump_ready = 0, dump_index, dump_data and dump_last are held stable.
  - At most one record transfers per cycle; full throughput when dump_ready stays high.
  - dump_last = 1 only with idx = NUM_REGS.
  - Handshake on the last record -> DONE, same edge: dump_valid = 0, done = 1.
- DONE:
  - done = 1 and cpu_stall = 1 hold. cause and cycle_count hold.
  - start -> RUN (cpu_stall = 0 and done = 0 next cycle), with clears identical to those from IDLE.
- reset in any state, including mid-DUMP: return to IDLE next cycle with reset values. A partial dump is dropped, with no further records.
- The cycle counter cannot overflow: RUN always exits at TIMEOUT_CYCLES.

Decomposition:
- Shared package mips_dbg_pkg:
  - state enum {IDLE, RUN, DUMP, DONE}
  - cause constants CAUSE_NONE, CAUSE_EXT, CAUSE_STABLE, CAUSE_TMO
  - clog2 helper
- One natural sub-module: dump_skid_reg, the single-entry valid/ready output register holding index, data and last.

Test Plan:
- Self-loop: PC steps 0x00, 0x04, ... 0x40, then holds 0x40; STABLE_CYCLES=4 -> cause=2; record 0 = 0x00000040; 33 records total, indices 0..32; done=1.
- Timeout: PC increments every cycle, TIMEOUT_CYCLES=100 -> stop after exactly 100 RUN cycles; cause=3; cycle_count=100.
- halt_req asserted on the same cycle that the timeout and the stable condition are met -> cause=1.
- dump_ready toggles 1,0,0,1 repeating, with register k preloaded to 0x1000+k -> records arrive in order, none dropped or duplicated, data held while stalled; dump_last only on index 32, whose data = 0x101F.
- reset asserted while index 10 is pending -> next cycle: dump_valid=0, cpu_stall=0, done=0, state IDLE; a new start gives a complete run and dump.
- start in DONE -> cpu_stall drops next cycle; cycle_count restarts at 0; second dump matches new register contents.
